// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard and memory-freeze controller at the ID/EX boundary.
// Detects a load in EX whose destination feeds the instruction in ID, holds
// PC and IF/ID while STALL_CYCLES bubbles enter ID/EX, freezes every stage
// while data memory is busy, and counts bubble and freeze cycles with
// saturating counters.
module load_use_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,  // bubbles per load-use hazard, 1..7
  parameter int CNT_W        = 32  // statistics counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             idex_flush,
  output logic             load_use1,
  output logic             load_use2,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // Bubbles still owed after the first one, loaded when a hazard is seen.
  localparam logic [2:0]       REM_INIT = 3'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [2:0]       rem_q, rem_d;
  logic             lu1_q, lu1_d;
  logic             lu2_q, lu2_d;
  logic [CNT_W-1:0] bubble_q, freeze_q;
  logic             m1, m2, hazard;
  logic             freeze_act;

  // Register $0 is hard-wired to zero, so a load targeting it never hazards.
  assign m1     = ex_mem_read & (ex_rd != 5'd0) & id_uses_rs & (id_rs == ex_rd);
  assign m2     = ex_mem_read & (ex_rd != 5'd0) & id_uses_rt & (id_rt == ex_rd);
  assign hazard = m1 | m2;

  // Leaving FREEZE behaves exactly like the state it interrupted, in the
  // same cycle, so decode that state directly once memory is ready.
  assign eff_state = ((state_q == ST_FREEZE) && !mem_busy) ? ret_q : state_q;

  // Next-state and output decode; memory-busy freeze has priority over stalls.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    ret_d      = ret_q;
    rem_d      = rem_q;
    lu1_d      = lu1_q;
    lu2_d      = lu2_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    idex_flush = 1'b0;
    load_use1  = 1'b0;
    load_use2  = 1'b0;
    freeze_act = 1'b0;

    case (eff_state)
      ST_RUN: begin
        if (mem_busy) begin
          freeze_act = 1'b1;
          state_d    = ST_FREEZE;
          ret_d      = ST_RUN;
        end else if (hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          load_use1  = m1;
          load_use2  = m2;
          if (STALL_CYCLES > 1) begin
            state_d = ST_BUBBLE;
            rem_d   = REM_INIT;
            lu1_d   = m1;
            lu2_d   = m2;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_BUBBLE: begin
        if (mem_busy) begin
          freeze_act = 1'b1;
          state_d    = ST_FREEZE;
          ret_d      = ST_BUBBLE;
        end else begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          load_use1  = lu1_q;
          load_use2  = lu2_q;
          rem_d      = rem_q - 3'd1;
          state_d    = (rem_q == 3'd1) ? ST_RUN : ST_BUBBLE;
        end
      end

      default: begin
        // Still frozen: memory remains busy, everything is held.
        freeze_act = 1'b1;
        state_d    = ST_FREEZE;
      end
    endcase

    if (freeze_act) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end

    // While reset is held the pipeline runs normally whatever the inputs.
    if (rst) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      idex_flush = 1'b0;
      load_use1  = 1'b0;
      load_use2  = 1'b0;
      freeze_act = 1'b0;
    end
  end

  // Control state registers; reset abandons any bubble or freeze in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      rem_q   <= 3'd0;
      lu1_q   <= 1'b0;
      lu2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      lu1_q   <= lu1_d;
      lu2_q   <= lu2_d;
    end
  end

  // Saturating statistics: bubbles inserted and cycles spent frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      freeze_q <= '0;
    end else begin
      if (idex_flush && (bubble_q != '1)) bubble_q <= bubble_q + CNT_ONE;
      if (freeze_act && (freeze_q != '1)) freeze_q <= freeze_q + CNT_ONE;
    end
  end

  assign bubble_cnt = bubble_q;
  assign freeze_cnt = freeze_q;

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Testbench for load_use_hazard_ctrl: four instances with different
// STALL_CYCLES / CNT_W share one stimulus stream. A directed vector table,
// hand-written multi-cycle sequences and a random phase are all checked
// against a cycle model built from the controller's behavioural rules.
module tb_load_use_hazard_ctrl;

  localparam int N_DUT = 4;

  function automatic int sc_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic int cw_of(input int g);
    return (g == 2) ? 4 : 32;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, mem_busy;

  logic [6:0]  out_w [N_DUT];  // {pc,ifid,idex,exmem,flush,lu1,lu2}
  logic [31:0] bub   [N_DUT];
  logic [31:0] frz   [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int CW = cw_of(g);
    logic [CW-1:0] bc, fc;
    logic pc, ifid, idex, exmem, fl, l1, l2;
    load_use_hazard_ctrl #(.STALL_CYCLES(sc_of(g)), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_busy(mem_busy),
      .pc_en(pc), .ifid_en(ifid), .idex_en(idex), .exmem_en(exmem),
      .idex_flush(fl), .load_use1(l1), .load_use2(l2),
      .bubble_cnt(bc), .freeze_cnt(fc)
    );
    assign out_w[g] = {pc, ifid, idex, exmem, fl, l1, l2};
    assign bub[g]   = 32'(bc);
    assign frz[g]   = 32'(fc);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bubbles still owed, their operand flags, counters.
  int     owed   [N_DUT], owed_n [N_DUT];
  bit     sv1    [N_DUT], sv1_n  [N_DUT];
  bit     sv2    [N_DUT], sv2_n  [N_DUT];
  longint bcnt   [N_DUT], bcnt_n [N_DUT];
  longint fcnt   [N_DUT], fcnt_n [N_DUT];
  bit     cnt_known = 1'b0;

  localparam logic [6:0] O_NORMAL = 7'b1111000;
  localparam logic [6:0] O_FREEZE = 7'b0000000;

  task automatic model_check();
    bit m1, m2;
    logic [6:0] e;
    longint mx;
    m1 = ex_mem_read && (ex_rd != 0) && id_uses_rs && (id_rs == ex_rd);
    m2 = ex_mem_read && (ex_rd != 0) && id_uses_rt && (id_rt == ex_rd);
    for (int g = 0; g < N_DUT; g++) begin
      mx = (longint'(1) << cw_of(g)) - 1;
      owed_n[g] = owed[g]; sv1_n[g] = sv1[g]; sv2_n[g] = sv2[g];
      bcnt_n[g] = bcnt[g]; fcnt_n[g] = fcnt[g];
      if (rst) begin
        e = O_NORMAL;
        owed_n[g] = 0; sv1_n[g] = 0; sv2_n[g] = 0; bcnt_n[g] = 0; fcnt_n[g] = 0;
      end else if (mem_busy) begin
        e = O_FREEZE;
        if (fcnt[g] < mx) fcnt_n[g] = fcnt[g] + 1;
      end else if (owed[g] > 0) begin
        e = {5'b00111, sv1[g], sv2[g]};
        owed_n[g] = owed[g] - 1;
        if (bcnt[g] < mx) bcnt_n[g] = bcnt[g] + 1;
      end else if (m1 || m2) begin
        e = {5'b00111, m1, m2};
        owed_n[g] = sc_of(g) - 1; sv1_n[g] = m1; sv2_n[g] = m2;
        if (bcnt[g] < mx) bcnt_n[g] = bcnt[g] + 1;
      end else begin
        e = O_NORMAL;
      end
      check($sformatf("model_out[%0d]", g), 32'(out_w[g]), 32'(e));
      if (cnt_known) begin
        check($sformatf("model_bub[%0d]", g), bub[g], 32'(bcnt[g]));
        check($sformatf("model_frz[%0d]", g), frz[g], 32'(fcnt[g]));
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic edge_step();
    bit was_rst;
    was_rst = rst;
    @(posedge clk);
    for (int g = 0; g < N_DUT; g++) begin
      owed[g] = owed_n[g]; sv1[g] = sv1_n[g]; sv2[g] = sv2_n[g];
      bcnt[g] = bcnt_n[g]; fcnt[g] = fcnt_n[g];
    end
    if (was_rst) cnt_known = 1'b1;
    #1;
  endtask

  task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic mr,
                        input logic [4:0] rd, input logic busy);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = mr; ex_rd = rd; mem_busy = busy;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    at_neg();
    edge_step();
  endtask

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] rd;
    logic       busy;
    logic [6:0] exp;
    int         ebub, efrz;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [6:0] seq_exp [7];

    // Expected values are for instance 0 (STALL_CYCLES=1, CNT_W=32).
    tbl[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 7'b1111000, 0, 0};
    tbl[1]  = '{1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 7'b0011110, 0, 0};
    tbl[2]  = '{1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 7'b1111000, 1, 0};
    tbl[3]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 7'b1111000, 1, 0};
    tbl[4]  = '{1'b0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 7'b1111000, 1, 0};
    tbl[5]  = '{1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 7'b0011101, 1, 0};
    tbl[6]  = '{1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 7'b0000000, 2, 0};
    tbl[7]  = '{1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 7'b0011101, 2, 1};
    tbl[8]  = '{1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 7'b0011111, 3, 1};
    tbl[9]  = '{1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 7'b1111000, 4, 1};
    tbl[10] = '{1'b0, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 7'b1111000, 0, 0};

    for (int g = 0; g < N_DUT; g++) begin
      owed[g] = 0; sv1[g] = 0; sv2[g] = 0; bcnt[g] = 0; fcnt[g] = 0;
    end

    do_reset();

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].r, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
             tbl[i].mr, tbl[i].rd, tbl[i].busy);
      at_neg();
      check($sformatf("tbl%0d_out", i), 32'(out_w[0]), 32'(tbl[i].exp));
      check($sformatf("tbl%0d_bub", i), bub[0], 32'(tbl[i].ebub));
      check($sformatf("tbl%0d_frz", i), frz[0], 32'(tbl[i].efrz));
      edge_step();
    end

    // Busy and hazard together: freeze wins, then the stall follows.
    do_reset();
    set_in(0, 8, 0, 1, 0, 1, 8, 1);
    at_neg(); check("busy_hz_freeze", 32'(out_w[0]), 32'(O_FREEZE)); edge_step();
    set_in(0, 8, 0, 1, 0, 1, 8, 0);
    at_neg(); check("busy_hz_stall", 32'(out_w[0]), 32'(7'b0011110)); edge_step();
    set_in(0, 8, 0, 1, 0, 0, 8, 0);
    at_neg(); check("busy_hz_normal", 32'(out_w[0]), 32'(O_NORMAL)); edge_step();
    check("busy_hz_bub", bub[0], 32'd1);
    check("busy_hz_frz", frz[0], 32'd1);

    // Three-bubble hazard on both operands (instance 1).
    do_reset();
    set_in(0, 5, 5, 1, 1, 1, 5, 0);
    at_neg(); check("sc3_b0", 32'(out_w[1]), 32'(7'b0011111)); edge_step();
    set_in(0, 5, 5, 1, 1, 0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check($sformatf("sc3_c%0d", i + 1), 32'(out_w[1]),
            32'((i < 2) ? 7'b0011111 : O_NORMAL));
      edge_step();
    end
    check("sc3_bub", bub[1], 32'd3);

    // Memory busy for 4 cycles starting at the second bubble (instance 1).
    do_reset();
    set_in(0, 5, 5, 1, 1, 1, 5, 0);
    at_neg(); check("frz_b0", 32'(out_w[1]), 32'(7'b0011111)); edge_step();
    seq_exp = '{O_FREEZE, O_FREEZE, O_FREEZE, O_FREEZE, 7'b0011111, 7'b0011111, O_NORMAL};
    for (int i = 0; i < 7; i++) begin
      set_in(0, 5, 5, 1, 1, 0, 5, (i < 4) ? 1'b1 : 1'b0);
      at_neg();
      check($sformatf("frz_c%0d", i + 1), 32'(out_w[1]), 32'(seq_exp[i]));
      edge_step();
    end
    check("frz_bub", bub[1], 32'd3);
    check("frz_frz", frz[1], 32'd4);

    // Reset during the second bubble leaves nothing behind (instance 1).
    do_reset();
    set_in(0, 5, 5, 1, 1, 1, 5, 0);
    at_neg(); check("rstb_b0", 32'(out_w[1]), 32'(7'b0011111)); edge_step();
    set_in(1, 5, 5, 1, 1, 0, 5, 0);
    at_neg(); check("rstb_in_rst", 32'(out_w[1]), 32'(O_NORMAL)); edge_step();
    set_in(0, 5, 5, 1, 1, 0, 5, 0);
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check($sformatf("rstb_after%0d", i), 32'(out_w[1]), 32'(O_NORMAL));
      check($sformatf("rstb_bub%0d", i), bub[1], 32'd0);
      check($sformatf("rstb_frz%0d", i), frz[1], 32'd0);
      edge_step();
    end

    // Saturation: 20 hazard cycles on a 4-bit counter (instance 2).
    do_reset();
    set_in(0, 3, 0, 1, 0, 1, 3, 0);
    for (int i = 0; i < 20; i++) begin
      at_neg();
      edge_step();
    end
    set_in(0, 3, 0, 1, 0, 0, 3, 0);
    at_neg();
    check("sat_bub4", bub[2], 32'd15);
    check("sat_bub32", bub[0], 32'd20);
    edge_step();

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      at_neg();
      edge_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
